pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the hard-coded IF/ID, ID/EX, EX/MEM and MEM/WB registers of the processor top with one reusable block. It carries an opaque payload of configurable width between two stages with a valid/ready handshake, an optional skid entry, a synchronous flush that inserts a bubble value, and a saturating stall counter for performance debug. The processor top instantiates one per stage boundary; the hazard unit drives `flush` and the downstream stage drives `out_ready`.

## Interface
- `DATA_W`, 64, payload width in bits (≥1)
- `SKID`, 1, 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `BUBBLE_VAL`, 0, value driven on `out_data` when the stage is empty or flushed (NOP encoding)
- `CNT_W`, 16, stall counter width
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — synchronous, active-low reset
- `flush` in 1 — discard all held entries this cycle
- `in_valid` in 1 — upstream payload valid
- `in_ready` out 1 — stage accepts payload this cycle
- `in_data` in DATA_W — upstream payload
- `out_valid` out 1 — payload on `out_data` valid
- `out_ready` in 1 — downstream accepts payload
- `out_data` out DATA_W — payload, `BUBBLE_VAL` when not valid
- `stall_cnt` out CNT_W — cycles with `out_valid && !out_ready`, saturating
- `stall_clr` in 1 — zero `stall_cnt`

## Operation
- Transfer in: `in_valid && in_ready`; transfer out: `out_valid && out_ready`.
- States (SKID=1): EMPTY, ONE (main full), TWO (main + skid full).
  - EMPTY: in → ONE.
  - ONE: in only → TWO; out only → EMPTY; in+out → ONE (main replaced with in_data).
  - TWO: out → ONE (skid moves to main); no input accepted.
  - `in_ready` = state != TWO, registered (from flops only).
- SKID=0: states EMPTY/ONE only; `in_ready` = EMPTY or `out_ready`; in+out in ONE keeps ONE with new data.
- Order preserved strictly FIFO; no payload duplicated or dropped except by flush.
- `out_data` = main entry when `out_valid`, else `BUBBLE_VAL`; never X after reset.
- Flush: next state EMPTY, both entries cleared to `BUBBLE_VAL`; any input offered in the flush cycle is discarded (flush wins over simultaneous in/out). `in_ready` still reports its normal value during the flush cycle.
- `stall_cnt` increments by 1 each cycle `out_valid && !out_ready`; holds at 2^CNT_W−1. `stall_clr` has priority over increment. Flush does not clear it.

## Timing
- Reset (`rst`=0 at a rising edge): state EMPTY, `out_valid`=0, `out_data`=`BUBBLE_VAL`, `stall_cnt`=0, `in_ready`=1.
- Latency: payload accepted at edge N is on `out_data` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained while `out_ready`=1, both SKID settings.
- SKID=1: downstream may deassert `out_ready` with no combinational path from `out_ready` to `in_ready`; the in-flight beat lands in skid.
- `out_valid`, `out_data`, `stall_cnt` driven from flops only. `in_ready` is combinational from `out_ready` only when SKID=0.
- Reset asserted mid-transfer overrides flush and handshakes; held entries lost.

## Structure
- Shared package `pipe_pkg`: state encoding (EMPTY=2'b00, ONE=2'b01, TWO=2'b10) and the default NOP bubble constant used as `BUBBLE_VAL` for instruction-carrying stages.
- No sub-module; a single module with a state register, two DATA_W entry registers, and the counter. Stage-specific packing of fields into `in_data` stays in the processor top.

## Test plan
- Reset: hold `rst`=0 two cycles with `in_valid`=1 → `out_valid`=0, `out_data`=`BUBBLE_VAL`, `stall_cnt`=0, `in_ready`=1.
- Streaming: SKID=1, `out_ready`=1, push 0x1..0x8 back-to-back → outputs 0x1..0x8 one per cycle, 1-cycle latency, no gaps.
- Backpressure: SKID=1, push 0xA,0xB,0xC, drop `out_ready` after 0xA is presented → 0xB held in skid, `in_ready`=0 next cycle, 0xC not accepted until `out_ready` returns; output order 0xA,0xB,0xC; `stall_cnt` equals stalled cycles.
- Flush: state TWO holding 0x11,0x22, assert `flush` with `in_valid`=1, `in_data`=0x33 → next cycle EMPTY, `out_valid`=0, `out_data`=`BUBBLE_VAL`; 0x33 never appears.
- SKID=0: `out_ready`=0 with ONE holding 0x5 → `in_ready`=0 same cycle; raise `out_ready` with `in_data`=0x6 → 0x5 leaves, 0x6 loaded same edge.
- Counter: CNT_W=4, stall 20 cycles → `stall_cnt` saturates at 15; `stall_clr` with active stall → 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the processor top.
package pipe_pkg;

    // Occupancy of a stage register: nothing held, main entry full, main + skid full.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StTwo   = 2'b10
    } stage_state_e;

    // Bubble for instruction-carrying stages (addi x0, x0, 0), zero-extended.
    localparam logic [63:0] NopBubble = 64'h0000_0000_0000_0013;

    // Bubble for data-only stages.
    localparam logic [63:0] ZeroBubble = 64'h0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage register with optional skid entry,
// synchronous flush to a bubble value and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter bit                SKID       = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = ZeroBubble[DATA_W-1:0],
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != StEmpty);
    // main_q is forced to BUBBLE_VAL whenever the stage empties, so it can drive out_data directly.
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register and the two payload entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and entry contents from the in/out handshakes; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && SKID) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE_VAL;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Stall counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (SKID) begin : g_skid_ready
        logic rdy_q;

        // Registered ready: precomputed from next state so out_ready never reaches in_ready.
        always_ff @(posedge clk) begin
            if (!rst) begin
                rdy_q <= 1'b1;
            end else begin
                rdy_q <= (state_d != StTwo);
            end
        end

        assign in_ready = rdy_q;
    end else begin : g_flow_ready
        assign in_ready = (state_q == StEmpty) || out_ready;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: DUT A has a skid entry and a 4-bit counter, DUT B is single-entry.
module tb_pipe_stage_reg;

    localparam int unsigned     DW    = 16;
    localparam logic [DW-1:0]   BUB_A = 16'h0013;
    localparam logic [DW-1:0]   BUB_B = 16'h00FF;

    logic clk = 1'b0;
    logic rst;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_stall_cnt;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [7:0]    b_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W     (DW),
        .SKID       (1'b1),
        .BUBBLE_VAL (BUB_A),
        .CNT_W      (4)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .stall_cnt (a_stall_cnt),
        .stall_clr (a_stall_clr)
    );

    pipe_stage_reg #(
        .DATA_W     (DW),
        .SKID       (1'b0),
        .BUBBLE_VAL (BUB_B),
        .CNT_W      (8)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .stall_cnt (b_stall_cnt),
        .stall_clr (b_stall_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        a_flush = 0; a_in_valid = 1; a_in_data = 16'h0077; a_out_ready = 1; a_stall_clr = 0;
        b_flush = 0; b_in_valid = 1; b_in_data = 16'h0077; b_out_ready = 1; b_stall_clr = 0;

        // Reset held two cycles with input offered.
        step();
        step();
        check_eq("rst_a_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst_a_data",  64'(a_out_data),  64'(BUB_A));
        check_eq("rst_a_cnt",   64'(a_stall_cnt), 64'd0);
        check_eq("rst_a_rdy",   64'(a_in_ready),  64'd1);
        check_eq("rst_b_valid", 64'(b_out_valid), 64'd0);
        check_eq("rst_b_data",  64'(b_out_data),  64'(BUB_B));
        rst = 1'b1;
        a_in_valid = 0;
        b_in_valid = 0;

        // Streaming 1..8 back to back with 1-cycle latency.
        a_in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 16'(i);
            step();
            check_eq($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
            check_eq($sformatf("stream_data_%0d", i),  64'(a_out_data),  64'(i));
            check_eq($sformatf("stream_rdy_%0d", i),   64'(a_in_ready),  64'd1);
        end
        a_in_valid = 0;
        step();
        check_eq("stream_drain_valid", 64'(a_out_valid), 64'd0);
        check_eq("stream_drain_data",  64'(a_out_data),  64'(BUB_A));
        check_eq("stream_cnt",         64'(a_stall_cnt), 64'd0);

        // Backpressure: A presented, then out_ready drops; B lands in skid, C waits.
        a_in_valid = 1; a_in_data = 16'h000A;
        step();
        check_eq("bp_a_out", 64'(a_out_data), 64'h000A);
        a_out_ready = 0; a_in_data = 16'h000B;
        step();
        check_eq("bp_rdy_low",  64'(a_in_ready),  64'd0);
        check_eq("bp_hold_a",   64'(a_out_data),  64'h000A);
        check_eq("bp_cnt1",     64'(a_stall_cnt), 64'd1);
        a_in_data = 16'h000C;
        step();
        check_eq("bp_rdy_low2", 64'(a_in_ready),  64'd0);
        check_eq("bp_hold_a2",  64'(a_out_data),  64'h000A);
        a_out_ready = 1;
        step();
        check_eq("bp_b_out",    64'(a_out_data),  64'h000B);
        check_eq("bp_rdy_back", 64'(a_in_ready),  64'd1);
        step();
        check_eq("bp_c_out",    64'(a_out_data),  64'h000C);
        a_in_valid = 0;
        step();
        check_eq("bp_drain",    64'(a_out_valid), 64'd0);
        check_eq("bp_cnt",      64'(a_stall_cnt), 64'd2);

        // Flush from TWO with a competing input.
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h0011;
        step();
        a_in_data = 16'h0022;
        step();
        check_eq("fl_two_data", 64'(a_out_data), 64'h0011);
        check_eq("fl_two_rdy",  64'(a_in_ready), 64'd0);
        a_flush = 1; a_in_data = 16'h0033;
        #1;
        check_eq("fl_rdy_during", 64'(a_in_ready), 64'd0);
        step();
        check_eq("fl_valid", 64'(a_out_valid), 64'd0);
        check_eq("fl_data",  64'(a_out_data),  64'(BUB_A));
        check_eq("fl_rdy",   64'(a_in_ready),  64'd1);
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        step();
        check_eq("fl_no_33",  64'(a_out_valid), 64'd0);
        check_eq("fl_cnt",    64'(a_stall_cnt), 64'd4);

        // Counter saturation at 15 with CNT_W=4, then clear under active stall.
        a_stall_clr = 1;
        step();
        check_eq("cnt_clr0", 64'(a_stall_cnt), 64'd0);
        a_stall_clr = 0; a_in_valid = 1; a_in_data = 16'h0044; a_out_ready = 0;
        step();
        a_in_valid = 0;
        for (int i = 0; i < 10; i++) step();
        check_eq("cnt_10", 64'(a_stall_cnt), 64'd10);
        for (int i = 0; i < 10; i++) step();
        check_eq("cnt_sat", 64'(a_stall_cnt), 64'd15);
        check_eq("cnt_hold_data", 64'(a_out_data), 64'h0044);
        a_stall_clr = 1;
        step();
        check_eq("cnt_clr", 64'(a_stall_cnt), 64'd0);
        a_stall_clr = 0;
        step();
        check_eq("cnt_resume", 64'(a_stall_cnt), 64'd1);

        // Reset mid-transfer overrides a simultaneous handshake.
        a_out_ready = 1; a_in_valid = 1; a_in_data = 16'h0055; rst = 0;
        step();
        check_eq("midrst_valid", 64'(a_out_valid), 64'd0);
        check_eq("midrst_data",  64'(a_out_data),  64'(BUB_A));
        check_eq("midrst_cnt",   64'(a_stall_cnt), 64'd0);
        rst = 1; a_in_valid = 0;
        step();

        // SKID=0: ready follows out_ready combinationally when full.
        b_in_valid = 1; b_in_data = 16'h0005; b_out_ready = 0;
        step();
        check_eq("b_one_data", 64'(b_out_data), 64'h0005);
        b_in_data = 16'h0006;
        #1;
        check_eq("b_rdy_low", 64'(b_in_ready), 64'd0);
        step();
        check_eq("b_hold5", 64'(b_out_data),  64'h0005);
        check_eq("b_cnt",   64'(b_stall_cnt), 64'd1);
        b_out_ready = 1;
        #1;
        check_eq("b_rdy_high", 64'(b_in_ready), 64'd1);
        step();
        check_eq("b_swap6",  64'(b_out_data),  64'h0006);
        check_eq("b_valid6", 64'(b_out_valid), 64'd1);
        for (int i = 7; i <= 9; i++) begin
            b_in_data = 16'(i);
            step();
            check_eq($sformatf("b_stream_%0d", i), 64'(b_out_data), 64'(i));
        end
        b_in_valid = 0;
        step();
        check_eq("b_drain_valid", 64'(b_out_valid), 64'd0);
        check_eq("b_drain_data",  64'(b_out_data),  64'(BUB_B));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
